// File: rtl/beta_dmem.sv
// beta_dmem: data-side memory responder for the beta core.
// Word-addressed RAM plus a memory-mapped timer that raises a level irq; loads are combinational.
module beta_dmem #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAddr,
   input  logic [31:0] memWriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] memReadData,
   output logic        irq
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [2:0] OFF_COUNT  = 3'd0;
   localparam logic [2:0] OFF_CMP    = 3'd1;
   localparam logic [2:0] OFF_CTRL   = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_RELOAD = 1;
   localparam int unsigned CTRL_IEN    = 2;

   logic [31:0]   r_ram [DEPTH];
   logic [31:0]   r_count;
   logic [31:0]   r_cmp;
   logic [2:0]    r_ctrl;
   logic          r_pend;

   logic          w_is_io;
   logic [AW-1:0] w_idx;
   logic [2:0]    w_off;
   logic          w_ram_we;
   logic          w_io_we;
   logic          w_match;
   logic [31:0]   w_count_nxt;
   logic          w_pend_nxt;
   logic [31:0]   w_io_rdata;
   logic [31:0]   w_ram_rdata;
   logic          w_unused;

   // Region decode: bit 31 picks IO, upper RAM index bits alias
   assign w_is_io  = memAddr[31];
   assign w_idx    = memAddr[AW+1:2];
   assign w_off    = memAddr[4:2];
   assign w_ram_we = MemWrite & ~w_is_io;
   assign w_io_we  = MemWrite & w_is_io;
   assign w_unused = ^{memAddr[30:AW+2], memAddr[1:0]};

   // RAM is never reset; a store during reset still lands
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_ram[w_idx] <= memWriteData;
      end
   end

   // Timer next state: core COUNT write beats reload/increment, a match beats W1C
   always_comb begin
      w_match     = r_ctrl[CTRL_EN] && (r_count == r_cmp);
      w_count_nxt = r_count;
      w_pend_nxt  = r_pend;
      if (r_ctrl[CTRL_EN]) begin
         w_count_nxt = (w_match && r_ctrl[CTRL_RELOAD]) ? 32'h0 : r_count + 32'd1;
      end
      if (w_io_we && (w_off == OFF_COUNT)) begin
         w_count_nxt = memWriteData;
      end
      if (w_io_we && (w_off == OFF_STATUS) && memWriteData[0]) begin
         w_pend_nxt = 1'b0;
      end
      if (w_match) begin
         w_pend_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 32'h0;
         r_cmp   <= 32'h0;
         r_ctrl  <= 3'b000;
         r_pend  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_pend  <= w_pend_nxt;
         if (w_io_we && (w_off == OFF_CMP)) begin
            r_cmp <= memWriteData;
         end
         if (w_io_we && (w_off == OFF_CTRL)) begin
            r_ctrl <= memWriteData[2:0];
         end
      end
   end

   always_comb begin
      w_io_rdata = 32'h0;
      case (w_off)
         OFF_COUNT:  w_io_rdata = r_count;
         OFF_CMP:    w_io_rdata = r_cmp;
         OFF_CTRL:   w_io_rdata = {29'd0, r_ctrl};
         OFF_STATUS: w_io_rdata = {31'd0, r_pend};
         default:    w_io_rdata = 32'h0;
      endcase
   end

   assign w_ram_rdata = r_ram[w_idx];
   assign memReadData = MemRead ? (w_is_io ? w_io_rdata : w_ram_rdata) : 32'h0;
   assign irq         = r_pend & r_ctrl[CTRL_IEN];

endmodule

// File: tb/tb_beta_dmem.sv
// Self-checking bench for beta_dmem: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of RAM and timer.
module tb_beta_dmem;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = $clog2(DEPTH);

   localparam logic [31:0] IO_COUNT  = 32'h8000_0000;
   localparam logic [31:0] IO_CMP    = 32'h8000_0004;
   localparam logic [31:0] IO_CTRL   = 32'h8000_0008;
   localparam logic [31:0] IO_STATUS = 32'h8000_000C;
   localparam logic [31:0] IO_UNMAP  = 32'h8000_0014;
   localparam logic [31:0] IO_LAST   = 32'h8000_001C;
   localparam logic [31:0] RAM_A4    = 32'h0000_0004;
   localparam logic [31:0] RAM_A4_AL = 32'(32'h4 + 4 * DEPTH);

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] memAddr;
   logic [31:0] memWriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] memReadData;
   logic        irq;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [31:0] m_ram [int];
   logic [31:0] m_count;
   logic [31:0] m_cmp;
   logic [2:0]  m_ctrl;
   logic        m_pend;

   beta_dmem #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .memAddr      (memAddr),
      .memWriteData (memWriteData),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .memReadData  (memReadData),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd,
                                              output logic known);
      int idx;
      known = 1'b1;
      if (!rd) return 32'h0;
      if (a[31]) begin
         case (a[4:2])
            3'd0:    return m_count;
            3'd1:    return m_cmp;
            3'd2:    return {29'd0, m_ctrl};
            3'd3:    return {31'd0, m_pend};
            default: return 32'h0;
         endcase
      end
      idx = int'(a[30:2] % DEPTH);
      if (m_ram.exists(idx)) return m_ram[idx];
      known = 1'b0;
      return 32'h0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven
   task automatic model_edge();
      logic        match;
      logic [31:0] nc;
      logic        np;
      int          idx;
      match = m_ctrl[0] && (m_count == m_cmp);
      idx   = int'(memAddr[30:2] % DEPTH);
      if (MemWrite && !memAddr[31]) m_ram[idx] = memWriteData;
      if (reset) begin
         m_count = 32'h0;
         m_cmp   = 32'h0;
         m_ctrl  = 3'b000;
         m_pend  = 1'b0;
         return;
      end
      nc = m_count;
      if (m_ctrl[0]) nc = (match && m_ctrl[1]) ? 32'h0 : m_count + 32'd1;
      np = m_pend || match;
      if (MemWrite && memAddr[31]) begin
         case (memAddr[4:2])
            3'd0:    nc = memWriteData;
            3'd1:    m_cmp = memWriteData;
            3'd2:    m_ctrl = memWriteData[2:0];
            3'd3:    if (memWriteData[0] && !match) np = 1'b0;
            default: ;
         endcase
      end
      m_count = nc;
      m_pend  = np;
   endtask

   task automatic set_bus(input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr);
      memAddr      = a;
      memWriteData = d;
      MemRead      = rd;
      MemWrite     = wr;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [31:0] a);
      set_bus(a, 32'h0, 1'b1, 1'b0);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      set_bus(a, d, 1'b0, 1'b1);
      tick();
   endtask

   task automatic idle();
      set_bus(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_bus(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_bus(IO_COUNT, 32'hBAD0_BAD0, 1'b1, 1'b1);
      tick();
      set_bus(IO_CTRL, 32'hFFFF_FFFF, 1'b0, 1'b1);
      tick();
      reset = 1'b0;
      set_bus(IO_COUNT, 32'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reset_rd_idle got=%h exp=%h", memReadData, 32'h0);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq got=%b exp=0", irq);
      end
      peek(IO_COUNT);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reset_count got=%h exp=%h", memReadData, 32'h0);
      end
      peek(IO_CMP);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reset_cmp got=%h exp=%h", memReadData, 32'h0);
      end
      peek(IO_CTRL);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reset_ctrl got=%h exp=%h", memReadData, 32'h0);
      end
      peek(IO_STATUS);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reset_status got=%h exp=%h", memReadData, 32'h0);
      end
      tick();
   endtask

   task automatic test_ram();
      wr(RAM_A4, 32'hDEAD_BEEF);
      wr(RAM_A4_AL, 32'h1234_5678);
      peek(RAM_A4);
      checks++;
      if (memReadData !== 32'h1234_5678) begin
         errors++; $display("FAIL ram_alias got=%h exp=%h", memReadData, 32'h1234_5678);
      end
      set_bus(RAM_A4, 32'hAAAA_5555, 1'b1, 1'b1);
      #1;
      checks++;
      if (memReadData !== 32'h1234_5678) begin
         errors++; $display("FAIL ram_rw_old got=%h exp=%h", memReadData, 32'h1234_5678);
      end
      tick();
      peek(RAM_A4);
      checks++;
      if (memReadData !== 32'hAAAA_5555) begin
         errors++; $display("FAIL ram_rw_new got=%h exp=%h", memReadData, 32'hAAAA_5555);
      end
      wr(32'h0000_03FC, 32'h0BAD_F00D);
      peek(32'h7FFF_FFFF);
      checks++;
      if (memReadData !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL ram_top_alias got=%h exp=%h", memReadData, 32'h0BAD_F00D);
      end
      tick();
   endtask

   task automatic test_oneshot();
      do_reset();
      wr(IO_CMP, 32'd5);
      wr(IO_CTRL, 32'h5);
      for (int k = 0; k <= 7; k++) begin
         peek(IO_COUNT);
         checks++;
         if (memReadData !== 32'(k)) begin
            errors++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, memReadData, 32'(k));
         end
         checks++;
         if (irq !== 1'(k >= 6)) begin
            errors++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, 1'(k >= 6));
         end
         tick();
      end
      wr(IO_STATUS, 32'h1);
      peek(IO_COUNT);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL oneshot_clear got=%b exp=0", irq);
      end
      checks++;
      if (memReadData !== 32'd9) begin
         errors++; $display("FAIL oneshot_count9 got=%h exp=%h", memReadData, 32'd9);
      end
      wr(IO_CTRL, 32'h0);
      peek(IO_COUNT);
      tick();
      peek(IO_COUNT);
      checks++;
      if (memReadData !== 32'd10) begin
         errors++; $display("FAIL oneshot_hold got=%h exp=%h", memReadData, 32'd10);
      end
      tick();
   endtask

   task automatic test_reload();
      do_reset();
      wr(IO_CMP, 32'd3);
      wr(IO_CTRL, 32'h7);
      for (int i = 0; i < 10; i++) begin
         peek(IO_COUNT);
         checks++;
         if (memReadData !== 32'(i % 4)) begin
            errors++; $display("FAIL reload_count i=%0d got=%h exp=%h", i, memReadData, 32'(i % 4));
         end
         checks++;
         if (irq !== 1'(i >= 4)) begin
            errors++; $display("FAIL reload_irq i=%0d got=%b exp=%b", i, irq, 1'(i >= 4));
         end
         tick();
      end
      wr(IO_STATUS, 32'h1);
      peek(IO_COUNT);
      checks++;
      if (irq !== 1'b0 || memReadData !== 32'd3) begin
         errors++; $display("FAIL reload_cleared irq=%b count=%h exp irq=0 count=3", irq, memReadData);
      end
      set_bus(IO_STATUS, 32'h1, 1'b1, 1'b1);
      #1;
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reload_w1c_old got=%h exp=%h", memReadData, 32'h0);
      end
      tick();
      peek(IO_STATUS);
      checks++;
      if (memReadData !== 32'h1 || irq !== 1'b1) begin
         errors++; $display("FAIL reload_match_beats_clear status=%h irq=%b exp status=1 irq=1", memReadData, irq);
      end
      peek(IO_COUNT);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL reload_wrap got=%h exp=%h", memReadData, 32'h0);
      end
      tick();
   endtask

   task automatic test_collision();
      do_reset();
      wr(IO_CTRL, 32'h1);
      idle();
      wr(IO_COUNT, 32'd100);
      peek(IO_COUNT);
      checks++;
      if (memReadData !== 32'd100) begin
         errors++; $display("FAIL coll_write got=%h exp=%h", memReadData, 32'd100);
      end
      tick();
      peek(IO_COUNT);
      checks++;
      if (memReadData !== 32'd101) begin
         errors++; $display("FAIL coll_inc got=%h exp=%h", memReadData, 32'd101);
      end
      wr(IO_CMP, 32'd7);
      wr(IO_STATUS, 32'h1);
      wr(IO_CTRL, 32'h5);
      wr(IO_COUNT, 32'hFFFF_FFFF);
      peek(IO_COUNT);
      checks++;
      if (memReadData !== 32'hFFFF_FFFF || irq !== 1'b0) begin
         errors++; $display("FAIL coll_preload count=%h irq=%b exp count=ffffffff irq=0", memReadData, irq);
      end
      tick();
      for (int k = 0; k <= 8; k++) begin
         peek(IO_COUNT);
         checks++;
         if (memReadData !== 32'(k) || irq !== 1'(k >= 8)) begin
            errors++; $display("FAIL coll_wrap k=%0d count=%h irq=%b exp count=%h irq=%b",
                               k, memReadData, irq, 32'(k), 1'(k >= 8));
         end
         tick();
      end
   endtask

   task automatic test_unmapped();
      do_reset();
      wr(IO_CMP, 32'h55);
      wr(IO_CTRL, 32'h2);
      wr(IO_UNMAP, 32'hFFFF_FFFF);
      peek(IO_UNMAP);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL unmap_read got=%h exp=%h", memReadData, 32'h0);
      end
      peek(IO_CTRL);
      checks++;
      if (memReadData !== 32'h2) begin
         errors++; $display("FAIL unmap_ctrl got=%h exp=%h", memReadData, 32'h2);
      end
      peek(IO_CMP);
      checks++;
      if (memReadData !== 32'h55) begin
         errors++; $display("FAIL unmap_cmp got=%h exp=%h", memReadData, 32'h55);
      end
      peek(IO_LAST);
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL unmap_last got=%h exp=%h", memReadData, 32'h0);
      end
      tick();
      wr(IO_CTRL, 32'hFFFF_FFFA);
      peek(IO_CTRL);
      checks++;
      if (memReadData !== 32'h2) begin
         errors++; $display("FAIL ctrl_upper got=%h exp=%h", memReadData, 32'h2);
      end
      set_bus(IO_CMP, 32'h0, 1'b0, 1'b0);
      #1;
      checks++;
      if (memReadData !== 32'h0) begin
         errors++; $display("FAIL io_noread got=%h exp=%h", memReadData, 32'h0);
      end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        rd;
      logic        we;
      logic        known;
      logic [2:0]  off;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         a = $urandom;
         a[31] = ($urandom_range(0, 1) == 1);
         if (a[31]) begin
            off = 3'($urandom_range(0, 7));
            if (off > 3'd4) off = 3'($urandom_range(0, 4));
            a[4:2] = off;
         end else begin
            a[AW+1:6] = '0;
         end
         d = $urandom;
         if (a[31] && (a[4:2] < 3'd2)) d = 32'($urandom_range(0, 24));
         rd = 1'($urandom_range(0, 1));
         we = ($urandom_range(0, 2) == 0);
         reset = ($urandom_range(0, 49) == 0);
         set_bus(a, d, rd, we);
         #1;
         exp_rd = model_read(a, rd, known);
         if (known) begin
            checks++;
            if (memReadData !== exp_rd) begin
               errors++; $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, a, memReadData, exp_rd);
            end
         end
         checks++;
         if (irq !== (m_pend & m_ctrl[2])) begin
            errors++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_pend & m_ctrl[2]);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      set_bus(32'h0, 32'h0, 1'b0, 1'b0);
      m_count = 32'h0;
      m_cmp   = 32'h0;
      m_ctrl  = 3'b000;
      m_pend  = 1'b0;
      test_reset();
      test_ram();
      test_oneshot();
      test_reload();
      test_collision();
      test_unmapped();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/beta_dmem.md
# beta_dmem

Data-side memory responder for the `beta` core. It answers the core's load/store port (`memAddr`, `memWriteData`, `MemRead`, `MemWrite`) with a word-addressed RAM and a small memory-mapped timer/interrupt block. The timer drives the core's `irq` input. Reads are combinational so the single-cycle core never stalls. Writes and all state updates occur on the rising clock edge.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; power of two, at least 2.
- `AW`, $clog2(DEPTH): RAM word-index width; derived, not overridden.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `memAddr` input 32: byte address from the core; bits [1:0] are ignored.
- `memWriteData` input 32: store data.
- `MemRead` input 1: load request this cycle.
- `MemWrite` input 1: store request this cycle.
- `memReadData` output 32: load data, combinational.
- `irq` output 1: interrupt request to the core, level-sensitive.

## Operation
- Region decode uses `memAddr[31]`. 0 selects RAM, with index `memAddr[AW+1:2]`; higher bits are ignored, so addresses alias modulo DEPTH words. 1 selects IO, with offset `memAddr[4:2]`.
- IO registers:
  - 0x0 COUNT: read/write, 32 bits.
  - 0x4 CMP: read/write, 32 bits.
  - 0x8 CTRL: bits [2:0] are read/write. bit0 EN, bit1 RELOAD, bit2 IEN. Upper bits read 0.
  - 0xC STATUS: bit0 PEND. Writing 1 to bit0 clears PEND; writing 0 has no effect. Upper bits read 0.
  - Offsets 0x10–0x1C read 0, and writes to them are ignored.
- Read path: `memReadData` equals the selected word while `MemRead`=1, and is 32'h0 while `MemRead`=0. There is no region or alignment error signalling.
- Write path: when `MemWrite`=1, the selected RAM word or IO register takes `memWriteData` at the edge.
- `MemRead` and `MemWrite` both high: the write is performed, and `memReadData` returns the pre-write contents.
- Timer, evaluated each edge when EN=1:
  - Match means COUNT==CMP.
  - On a match, PEND is set. COUNT then goes to 0 if RELOAD=1; otherwise it increments.
  - With no match, COUNT increments. It wraps from 32'hFFFFFFFF to 0.
  - When EN=0, COUNT holds and no match is evaluated.
- `irq` = PEND & IEN, combinational from registers; no extra flop.
- Priority, highest first:
  - A core write to COUNT overrides increment and reload in the same cycle.
  - A match that sets PEND overrides a same-cycle write-1-clear, so PEND stays 1.
  - A write to CMP or CTRL takes effect for match evaluation from the next cycle; the current cycle uses the old value.
- Reset: COUNT, CMP, CTRL and PEND clear to 0; `irq`=0. RAM contents are not reset, so they are undefined after power-up and preserved across `reset`. A store coincident with `reset`=1 is dropped for IO registers; the RAM write is still performed.

## Timing
- Load latency is 0 cycles: data is valid in the same cycle as `MemRead`/`memAddr`.
- Store latency is 1 edge: a read of the same address on the following cycle returns the new value.
- Timer match at cycle t, where COUNT==CMP with EN=1 before edge t+1: PEND=1 and `irq`=1 (if IEN) from edge t+1.
- Enabling with COUNT=0 and CMP=0 gives a match on the first enabled cycle.
- Clearing PEND: the STATUS write at cycle t drops `irq` after edge t+1, unless a new match occurs in cycle t.
- With RELOAD=1 and CMP=N, PEND asserts every N+1 cycles.

## Test plan
- Reset: drive `reset` for 2 cycles with garbage on the bus → COUNT=CMP=CTRL=0, `irq`=0, and `memReadData`=0 with `MemRead`=0.
- RAM: store 32'hDEADBEEF at 0x4, then 32'h12345678 at 0x4+4·DEPTH (alias); load 0x4 → 32'h12345678. Store with simultaneous `MemRead` returns the old value that cycle.
- One-shot timer: CMP=5, CTRL=3'b101. COUNT runs 0..5, `irq` rises the edge after COUNT==5, and COUNT continues 6, 7…. Write 1 to STATUS → `irq` low next cycle.
- Auto-reload: CMP=3, CTRL=3'b111. COUNT sequence is 0,1,2,3,0,1…, and PEND re-sets every 4 cycles. A write-1-clear in the match cycle leaves `irq`=1.
- Collisions: write COUNT=100 during an enabled increment → next read is 100. Preload COUNT=32'hFFFFFFFF with CMP=7 → COUNT wraps to 0 and no `irq` until COUNT reaches 7.
- Unmapped IO: store to 0x80000014, load 0x80000014 and CTRL upper bits → reads return 0 and no register changes.
